// File: rtl/zx_mem_pkg.sv
// Shared types and constants for the ZX video/CPU memory subsystem.
package zx_mem_pkg;

   typedef enum logic [1:0] {IDLE, VID_RD, CPU_RD, CPU_WR} arb_state_t;

   localparam int  RAM_AW        = 14;
   localparam byte CPU_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous RAM between the ULA video fetcher and the CPU.
// Video has priority; the CPU is stalled via cpu_nwait and wins after waiting MAX_CPU_WAIT cycles.
module vram_arbiter
   import zx_mem_pkg::*;
#(
   parameter int unsigned AW           = RAM_AW,
   parameter int unsigned RAM_LAT      = 1,
   parameter int unsigned MAX_CPU_WAIT = 6
) (
   input  logic          clk_vram,
   input  logic          nreset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [7:0]    vid_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_nwait,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   output logic          ram_we,
   input  logic [7:0]    ram_q
);

   localparam logic [1:0] LAT_LAST = 2'(RAM_LAT);
   localparam logic [3:0] WAIT_LIM = 4'(MAX_CPU_WAIT);

   arb_state_t    state_q, state_d;
   logic [1:0]    lat_cnt_q, lat_cnt_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d;
   logic          served_q, served_d;
   logic [AW-1:0] ram_addr_d;
   logic [7:0]    ram_wdata_d;
   logic          ram_we_d;
   logic          vid_ack_d, cpu_ack_d;
   logic [7:0]    vid_rdata_d, cpu_rdata_d;
   logic          cpu_nwait_d;
   logic          cpu_pend, starve, grant_cpu, grant_vid, cpu_busy;

   always_comb begin
      cpu_pend    = cpu_req & ~served_q;
      starve      = cpu_pend & (wait_cnt_q >= WAIT_LIM);
      grant_cpu   = 1'b0;
      grant_vid   = 1'b0;
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      ram_addr_d  = ram_addr;
      ram_wdata_d = ram_wdata;
      ram_we_d    = 1'b0;
      vid_ack_d   = 1'b0;
      cpu_ack_d   = 1'b0;
      vid_rdata_d = vid_rdata;
      cpu_rdata_d = cpu_rdata;

      case (state_q)
         IDLE: begin
            if (starve || (cpu_pend && !vid_req)) begin
               grant_cpu = 1'b1;
            end else if (vid_req) begin
               grant_vid = 1'b1;
            end
            if (grant_cpu) begin
               state_d     = cpu_we ? CPU_WR : CPU_RD;
               ram_addr_d  = cpu_addr;
               ram_wdata_d = cpu_wdata;
               ram_we_d    = cpu_we;
               // A write completes in the single cycle it drives the RAM.
               cpu_ack_d   = cpu_we;
               lat_cnt_d   = 2'd0;
            end else if (grant_vid) begin
               state_d    = VID_RD;
               ram_addr_d = vid_addr;
               lat_cnt_d  = 2'd0;
            end
         end
         CPU_WR: state_d = IDLE;
         VID_RD, CPU_RD: begin
            if (lat_cnt_q == LAT_LAST) begin
               state_d = IDLE;
               if (state_q == VID_RD) begin
                  vid_ack_d   = 1'b1;
                  vid_rdata_d = ram_q;
               end else begin
                  cpu_ack_d   = 1'b1;
                  cpu_rdata_d = ram_q;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      cpu_busy    = (state_q == CPU_RD) || (state_q == CPU_WR);
      // served blocks a second access for the same strobe assertion.
      served_d    = cpu_req & (served_q | cpu_ack_d);
      cpu_nwait_d = ~(cpu_pend & ~cpu_ack_d);

      if (!cpu_pend || grant_cpu || cpu_busy) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q != 4'hF) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   always_ff @(posedge clk_vram or negedge nreset) begin
      if (!nreset) begin
         state_q    <= IDLE;
         lat_cnt_q  <= 2'd0;
         wait_cnt_q <= 4'd0;
         served_q   <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= 8'h00;
         ram_we     <= 1'b0;
         vid_ack    <= 1'b0;
         cpu_ack    <= 1'b0;
         vid_rdata  <= 8'h00;
         cpu_rdata  <= CPU_IDLE_DATA;
         cpu_nwait  <= 1'b1;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         served_q   <= served_d;
         ram_addr   <= ram_addr_d;
         ram_wdata  <= ram_wdata_d;
         ram_we     <= ram_we_d;
         vid_ack    <= vid_ack_d;
         cpu_ack    <= cpu_ack_d;
         vid_rdata  <= vid_rdata_d;
         cpu_rdata  <= cpu_rdata_d;
         cpu_nwait  <= cpu_nwait_d;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios then randomized traffic,
// compared against a timeline-based reference model and a separate RAM model.
module tb_vram_arbiter;

   localparam int unsigned AW   = 14;
   localparam int unsigned LAT  = 1;
   localparam int unsigned MAXW = 6;

   logic          clk_vram = 1'b0;
   logic          nreset   = 1'b0;
   logic          vid_req  = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          vid_ack;
   logic [7:0]    vid_rdata;
   logic          cpu_req  = 1'b0;
   logic          cpu_we   = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_wdata = 8'h00;
   logic          cpu_ack;
   logic [7:0]    cpu_rdata;
   logic          cpu_nwait;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic          ram_we;
   logic [7:0]    ram_q;

   vram_arbiter #(.AW(AW), .RAM_LAT(LAT), .MAX_CPU_WAIT(MAXW)) dut (
      .clk_vram (clk_vram),
      .nreset   (nreset),
      .vid_req  (vid_req),
      .vid_addr (vid_addr),
      .vid_ack  (vid_ack),
      .vid_rdata(vid_rdata),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack  (cpu_ack),
      .cpu_rdata(cpu_rdata),
      .cpu_nwait(cpu_nwait),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_we   (ram_we),
      .ram_q    (ram_q)
   );

   always #5 clk_vram = ~clk_vram;

   // Synchronous RAM with LAT cycles of read latency.
   logic [7:0] ram_mem [0:(1<<AW)-1];
   logic [7:0] q_pipe  [0:LAT-1];
   assign ram_q = q_pipe[LAT-1];

   always @(posedge clk_vram) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      q_pipe[0] <= ram_mem[ram_addr];
      for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
   end

   // Reference model: transaction timeline in absolute cycle numbers.
   logic [7:0]    ref_mem [0:(1<<AW)-1];
   int            cyc_n, free_at, vid_ack_at, cpu_ack_at, we_at, cpu_grant_at, m_wait;
   bit            m_served, cpu_is_rd;
   logic [7:0]    p_vid, p_cpu;
   logic          e_vid_ack, e_cpu_ack, e_we, e_nwait;
   logic [7:0]    e_vid_rdata, e_cpu_rdata, e_wdata;
   logic [AW-1:0] e_ram_addr;

   int n_checks = 0;
   int n_err    = 0;
   int n_vack, n_cack;

   function automatic logic [7:0] init_val(int i);
      return 8'(i) ^ 8'(i >> 6) ^ 8'h3C;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc_n = 0; free_at = 0; vid_ack_at = -10; cpu_ack_at = -10; we_at = -10;
      cpu_grant_at = -10; m_wait = 0; m_served = 0; cpu_is_rd = 0;
      e_vid_ack = 0; e_cpu_ack = 0; e_we = 0; e_nwait = 1;
      e_vid_rdata = 8'h00; e_cpu_rdata = 8'hFF; e_ram_addr = '0; e_wdata = 8'h00;
   endtask

   // Computes expected outputs for cycle cyc_n+1 from the inputs of cycle cyc_n.
   task automatic model_step();
      bit pend, gcpu, gvid, in_flight;
      pend = cpu_req && !m_served;
      gcpu = 0;
      gvid = 0;
      if (cyc_n >= free_at) begin
         if (pend && (m_wait >= int'(MAXW) || !vid_req)) gcpu = 1;
         else if (vid_req) gvid = 1;
      end
      if (gcpu) begin
         e_ram_addr   = cpu_addr;
         cpu_grant_at = cyc_n;
         cpu_is_rd    = !cpu_we;
         if (cpu_we) begin
            ref_mem[cpu_addr] = cpu_wdata;
            e_wdata    = cpu_wdata;
            cpu_ack_at = cyc_n + 1;
            we_at      = cyc_n + 1;
            free_at    = cyc_n + 2;
         end else begin
            p_cpu      = ref_mem[cpu_addr];
            cpu_ack_at = cyc_n + 2 + LAT;
            free_at    = cpu_ack_at;
         end
      end else if (gvid) begin
         e_ram_addr = vid_addr;
         p_vid      = ref_mem[vid_addr];
         vid_ack_at = cyc_n + 2 + LAT;
         free_at    = vid_ack_at;
      end
      e_vid_ack = (vid_ack_at == cyc_n + 1);
      e_cpu_ack = (cpu_ack_at == cyc_n + 1);
      e_we      = (we_at == cyc_n + 1);
      if (e_vid_ack) e_vid_rdata = p_vid;
      if (e_cpu_ack && cpu_is_rd) e_cpu_rdata = p_cpu;
      e_nwait   = !(pend && !e_cpu_ack);
      in_flight = (cyc_n > cpu_grant_at) && (cyc_n < cpu_ack_at);
      if (!pend || gcpu || in_flight) m_wait = 0;
      else if (m_wait < 15) m_wait++;
      m_served = cpu_req && (m_served || e_cpu_ack);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_vram);
      #1;
      cyc_n++;
      chk("vid_ack", vid_ack, e_vid_ack);
      chk("cpu_ack", cpu_ack, e_cpu_ack);
      chk("ram_we", ram_we, e_we);
      chk("cpu_nwait", cpu_nwait, e_nwait);
      chk("vid_rdata", vid_rdata, e_vid_rdata);
      chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
      chk("ram_addr", ram_addr, e_ram_addr);
      if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
      if (vid_ack) n_vack++;
      if (cpu_ack) n_cack++;
   endtask

   task automatic reset_outputs_chk(string tag);
      chk({tag, "_vid_ack"}, vid_ack, 1'b0);
      chk({tag, "_cpu_ack"}, cpu_ack, 1'b0);
      chk({tag, "_ram_we"}, ram_we, 1'b0);
      chk({tag, "_nwait"}, cpu_nwait, 1'b1);
      chk({tag, "_cpu_rdata"}, cpu_rdata, 8'hFF);
      chk({tag, "_vid_rdata"}, vid_rdata, 8'h00);
      chk({tag, "_ram_addr"}, ram_addr, 14'h0000);
   endtask

   // Asserts reset mid-cycle, checks it across edges, releases it 1 ns after an edge.
   task automatic do_reset(input bit vr);
      nreset  = 1'b0;
      vid_req = vr;
      cpu_req = 1'b0;
      #1;
      reset_outputs_chk("rst_async");
      repeat (2) @(posedge clk_vram);
      #1;
      reset_outputs_chk("rst_held");
      nreset = 1'b1;
      model_reset();
      n_vack = 0;
      n_cack = 0;
   endtask

   initial begin
      int  ack_rel, low, vid_after, hold;
      bit  got, cpu_done;

      for (int i = 0; i < (1 << AW); i++) begin
         ram_mem[i] <= init_val(i);
         ref_mem[i]  = init_val(i);
      end
      model_reset();
      @(posedge clk_vram);
      #1;

      // 1: reset with video requesting; video is granted first after release.
      vid_addr = 14'h0123;
      do_reset(1'b1);
      got = 0;
      for (int r = 0; r < 10; r++) begin
         tick();
         if (vid_ack) begin
            vid_req = 1'b0;
            got     = 1;
         end
      end
      chk("t1_vid_served", got, 1'b1);

      // 2: CPU write then read-back of the same address.
      do_reset(1'b0);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1800; cpu_wdata = 8'h5A;
      tick();
      chk("t2_wr_ack", cpu_ack, 1'b1);
      chk("t2_wr_we", ram_we, 1'b1);
      cpu_req = 1'b0;
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0;
      got = 0;
      for (int r = 0; r < 10 && !got; r++) begin
         tick();
         if (cpu_ack) got = 1;
      end
      cpu_req = 1'b0;
      chk("t2_rd_ack_seen", got, 1'b1);
      chk("t2_rd_data", cpu_rdata, 8'h5A);
      tick();

      // 3: video and CPU read rise together; video first, CPU right after.
      do_reset(1'b0);
      vid_req = 1'b1; vid_addr = 14'h0100;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
      ack_rel = -1;
      low     = 0;
      for (int r = 1; r <= 10; r++) begin
         tick();
         if (!cpu_nwait) low++;
         if (cpu_ack && ack_rel < 0) ack_rel = r;
         if (vid_ack) vid_req = 1'b0;
         if (cpu_ack) cpu_req = 1'b0;
      end
      chk("t3_cpu_ack_cycle", ack_rel, 6);
      chk("t3_nwait_low_cycles", low, 5);

      // 4: continuous video; CPU wins once by starvation, then video resumes.
      do_reset(1'b0);
      vid_req = 1'b1; vid_addr = 14'h0300;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
      vid_after = 0;
      for (int r = 0; r < 40; r++) begin
         tick();
         if (vid_ack) begin
            vid_addr = vid_addr + 14'd1;
            if (n_cack > 0) vid_after++;
         end
         if (cpu_ack) cpu_req = 1'b0;
      end
      vid_req = 1'b0;
      chk("t4_cpu_acks", n_cack, 1);
      chk("t4_vid_resumed", vid_after > 0, 1'b1);
      repeat (4) tick();

      // 5: CPU holds its strobe long: exactly one access, then a second on re-assertion.
      do_reset(1'b0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0042;
      repeat (20) tick();
      chk("t5_one_ack", n_cack, 1);
      chk("t5_nwait_after", cpu_nwait, 1'b1);
      cpu_req = 1'b0;
      tick();
      cpu_req = 1'b1;
      repeat (8) tick();
      chk("t5_second_ack", n_cack, 2);
      cpu_req = 1'b0;
      tick();

      // 6a: CPU cancels while video holds the RAM.
      do_reset(1'b0);
      vid_req = 1'b1; vid_addr = 14'h0500;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0600; cpu_wdata = 8'hC3;
      tick();
      tick();
      cpu_req = 1'b0;
      for (int r = 0; r < 8; r++) begin
         tick();
         if (vid_ack) vid_req = 1'b0;
      end
      chk("t6_cancel_no_ack", n_cack, 0);

      // 6b: reset in the middle of a video read abandons it.
      do_reset(1'b0);
      vid_req = 1'b1; vid_addr = 14'h0700;
      tick();
      tick();
      do_reset(1'b0);
      repeat (6) tick();
      chk("t6_reset_no_vid_ack", n_vack, 0);

      // Randomized traffic from protocol-following video and CPU agents.
      do_reset(1'b0);
      cpu_done = 0;
      hold     = 0;
      for (int r = 0; r < 1500; r++) begin
         tick();
         if (vid_req && vid_ack) begin
            vid_req = 1'b0;
         end else if (!vid_req && $urandom_range(0, 3) == 0) begin
            vid_req  = 1'b1;
            vid_addr = 14'($urandom_range(0, 63));
         end
         if (cpu_req) begin
            if (cpu_ack) cpu_done = 1;
            if (cpu_done) begin
               if (hold == 0) cpu_req = 1'b0;
               else hold--;
            end else if (!cpu_nwait && $urandom_range(0, 40) == 0) begin
               cpu_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 14'($urandom_range(0, 63));
            cpu_wdata = 8'($urandom);
            hold      = $urandom_range(0, 3);
            cpu_done  = 0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
